tdm_demux4: RTL and testbench

- Four-channel time-division demultiplexer and deserializer: the receive-side counterpart of the team's 4:1 bit mux driven by a rotating select.
- Takes a serial stream with one bit per slot, slots ordered channel 0,1,2,3 and repeating, and rebuilds one W-bit word per channel.
- A start-of-frame pulse marks frame alignment. A small state machine acquires and checks that alignment.
- Sits between the serial link and the per-channel parallel consumers.

---
 rtl/tdm_pkg.sv | 14 +
 rtl/tdm_deser_lane.sv | 43 ++++
 rtl/tdm_demux4.sv | 121 ++++++++++++
 tb/tb_tdm_demux4.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 4-channel TDM demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdm_pkg;

    localparam int NCH    = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_deser_lane.sv
// One channel lane: MSB-first shift register plus held output word and valid pulse.
// Latency: word/word_valid update 1 clk after the completing load_en beat.
// Backpressure: none; the lane only moves when shift_en/load_en are asserted.
module tdm_deser_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         bit_in,
    input  logic         load_en,
    input  logic         clear,
    output logic [W-1:0] word,
    output logic         word_valid
);

    logic [W-1:0] sr;

    // Shift register: clear drops any partial word; a simultaneous shift seeds the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (clear) begin
            sr <= shift_en ? {{(W-1){1'b0}}, bit_in} : '0;
        end else if (shift_en) begin
            sr <= {sr[W-2:0], bit_in};
        end
    end

    // Output word takes the last W-1 shifted bits plus the completing bit; pulse valid with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= load_en;
            if (load_en) begin
                word <= {sr[W-2:0], bit_in};
            end
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM deserializer: sof-acquired framing, flywheel lock, per-channel W-bit words.
// Latency: 1 clk from the completing beat to dout field update and ch_valid pulse.
// Backpressure: none; din_valid low stalls the slot/frame counters and all lanes.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [NCH*W-1:0] dout,
    output logic [NCH-1:0]   ch_valid,
    output logic             lock,
    output logic             sync_err
);

    localparam int                FRAME_W    = $clog2(W);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(W - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NCH - 1);

    state_t              state, state_nxt;
    logic [SLOT_W-1:0]   slot, slot_nxt;
    logic [FRAME_W-1:0]  frame, frame_nxt;
    logic                serr_nxt;
    logic [NCH-1:0]      shift_en;
    logic [NCH-1:0]      load_en;
    logic                clear;
    logic                at_origin;

    assign at_origin = (frame == '0) && (slot == '0);
    assign lock      = (state == LOCKED);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Slot/frame position and the registered sync_err pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot     <= '0;
            frame    <= '0;
            sync_err <= 1'b0;
        end else begin
            slot     <= slot_nxt;
            frame    <= frame_nxt;
            sync_err <= serr_nxt;
        end
    end

    // Next state, counter advance, sof check and lane enable decode.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        frame_nxt = frame;
        serr_nxt  = 1'b0;
        shift_en  = '0;
        load_en   = '0;
        clear     = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (sof) begin
                        // Acquire: this beat is channel 0 MSB of a fresh group.
                        state_nxt   = LOCKED;
                        clear       = 1'b1;
                        shift_en[0] = 1'b1;
                        slot_nxt    = SLOT_W'(1);
                        frame_nxt   = '0;
                    end
                end
                LOCKED: begin
                    if (sof && !at_origin) begin
                        // Misplaced sof: drop partial words and realign on this beat.
                        serr_nxt    = 1'b1;
                        clear       = 1'b1;
                        shift_en[0] = 1'b1;
                        slot_nxt    = SLOT_W'(1);
                        frame_nxt   = '0;
                    end else begin
                        shift_en[slot] = 1'b1;
                        if (frame == FRAME_LAST) begin
                            load_en[slot] = 1'b1;
                        end
                        slot_nxt = slot + SLOT_W'(1);
                        if (slot == SLOT_LAST) begin
                            frame_nxt = (frame == FRAME_LAST) ? '0 : frame + FRAME_W'(1);
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_lane
            tdm_deser_lane #(
                .W (W)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .shift_en   (shift_en[k]),
                .bit_in     (din),
                .load_en    (load_en[k]),
                .clear      (clear),
                .word       (dout[k*W +: W]),
                .word_valid (ch_valid[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (W = 8) with a scoreboard of expected words.
// Latency: checks each ch_valid pulse one cycle after its completing beat.
// Backpressure: random din_valid stalls exercised in selected groups.
module tb_tdm_demux4;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          din;
    logic          din_valid;
    logic          sof;
    logic [4*W-1:0] dout;
    logic [3:0]    ch_valid;
    logic          lock;
    logic          sync_err;

    typedef struct packed {
        logic [1:0]   ch;
        logic [W-1:0] w;
    } exp_t;

    exp_t sb[$];

    int   n_tests = 0;
    int   n_fail  = 0;

    logic [3:0] exp_vld  = 4'b0;
    logic       exp_serr = 1'b0;
    logic       exp_lock = 1'b0;

    tdm_demux4 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .sof       (sof),
        .dout      (dout),
        .ch_valid  (ch_valid),
        .lock      (lock),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check the outputs produced by the previous edge, then apply the next cycle's inputs.
    task automatic tick(input logic v, input logic b, input logic s,
                        input logic [3:0] ev, input logic es);
        exp_t e;
        @(negedge clk);
        check("ch_valid", 32'(ch_valid), 32'(exp_vld));
        check("sync_err", 32'(sync_err), 32'(exp_serr));
        check("lock", 32'(lock), 32'(exp_lock));
        if (ch_valid != 4'b0) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(ch_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                check("dout_field", 32'(dout[int'(e.ch)*W +: W]), 32'(e.w));
            end
        end
        din_valid = v;
        din       = b;
        sof       = s;
        exp_vld   = ev;
        exp_serr  = es;
        if (v && s) exp_lock = 1'b1;
    endtask

    // Drive nbeats beats of a word group built from words = {ch3,ch2,ch1,ch0}.
    task automatic send_beats(input logic [31:0] words, input int nbeats, input logic sof_first,
                              input int stall_pct, input logic serr_first);
        exp_t       e;
        logic [3:0] ev;
        int         c;
        int         f;
        for (int n = 0; n < nbeats; n++) begin
            c = n % 4;
            f = n / 4;
            while (int'($urandom_range(99)) < stall_pct) begin
                tick(1'b0, 1'($urandom), 1'($urandom), 4'b0, 1'b0);
            end
            ev = (f == W - 1) ? (4'b0001 << c) : 4'b0;
            tick(1'b1, words[c*W + (W - 1 - f)], sof_first && (n == 0), ev, serr_first && (n == 0));
            if (f == W - 1) begin
                e.ch = 2'(c);
                e.w  = words[c*W +: W];
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        sof       = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_dout", dout, 32'h0);
        check("reset_ch_valid", 32'(ch_valid), 32'h0);
        check("reset_lock", 32'(lock), 32'h0);
        check("reset_sync_err", 32'(sync_err), 32'h0);
        rst = 1'b0;

        // No sof: every beat discarded.
        for (int i = 0; i < 40; i++) tick(1'b1, 1'(i % 2), 1'b0, 4'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        check("hunt_dout", dout, 32'h0);

        // Acquire and decode a clean group.
        send_beats({8'h01, 8'hFF, 8'h3C, 8'hA5}, 32, 1'b1, 0, 1'b0);
        // Same data, sof at the expected position, with stalls.
        send_beats({8'h01, 8'hFF, 8'h3C, 8'hA5}, 32, 1'b1, 30, 1'b0);
        // Flywheel group without sof.
        send_beats({8'h80, 8'h00, 8'hC3, 8'h5A}, 32, 1'b0, 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        check("flywheel_dout", dout, {8'h80, 8'h00, 8'hC3, 8'h5A});

        // 13 beats of a group, then a misplaced sof starting a full group.
        send_beats({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 13, 1'b0, 0, 1'b0);
        send_beats({8'h78, 8'h56, 8'h34, 8'h12}, 32, 1'b1, 0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        check("resync_dout", dout, {8'h78, 8'h56, 8'h34, 8'h12});

        // Reset after 20 beats of a group.
        send_beats({8'hDE, 8'hAD, 8'hBE, 8'hEF}, 20, 1'b0, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_dout", dout, 32'h0);
        check("midrst_lock", 32'(lock), 32'h0);
        check("midrst_ch_valid", 32'(ch_valid), 32'h0);
        exp_lock = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        rst = 1'b0;
        send_beats({8'h55, 8'hAA, 8'h55, 8'hAA}, 12, 1'b0, 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        check("postrst_dout", dout, 32'h0);
        send_beats({8'h9C, 8'h47, 8'hE1, 8'h2B}, 32, 1'b1, 30, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        check("final_dout", dout, {8'h9C, 8'h47, 8'hE1, 8'h2B});
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
